stopwatch_time_counter: RTL and testbench

Downstream timekeeping stage of the digital stopwatch, driven by the control FSM's run_enable and its return-to-IDLE clear. It prescales clk to a 1 Hz tick and counts elapsed time as minutes:seconds. Binary and BCD values go to the display/seven-segment driver. Pausing freezes both the time and the partial-second prescaler, so resume is seamless.

---
 rtl/stopwatch_time_counter_if.sv | 22 ++
 rtl/stopwatch_time_counter.sv | 90 +++++++++
 tb/tb_stopwatch_time_counter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_time_counter_if.sv
// Stopwatch timekeeping bus: control inputs from the FSM,
// binary/BCD time and pulse outputs toward the display driver.
interface stopwatch_time_counter_if;
    logic       run_enable;
    logic       clear;
    logic [5:0] seconds;
    logic [6:0] minutes;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic       sec_tick;
    logic       wrap;

    modport master (
        output run_enable, clear,
        input  seconds, minutes, sec_bcd, min_bcd, sec_tick, wrap
    );

    modport slave (
        input  run_enable, clear,
        output seconds, minutes, sec_bcd, min_bcd, sec_tick, wrap
    );
endinterface

// File: rtl/stopwatch_time_counter.sv
// Stopwatch timekeeping: 1 Hz prescaler and mm:ss counter with
// parallel registered BCD digit counters.
module stopwatch_time_counter #(
    parameter int TICK_DIV = 100_000_000,
    parameter int MAX_MIN  = 99
) (
    input  logic clk,
    input  logic rst_n,
    stopwatch_time_counter_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0] r_pre;
    logic [5:0]    r_sec;
    logic [6:0]    r_min;
    logic [3:0]    r_sec_o, r_sec_t;
    logic [3:0]    r_min_o, r_min_t;
    logic          r_tick, r_wrap;

    logic w_term, w_sec_last, w_min_last;

    assign w_term     = bus.run_enable && (r_pre == PW'(TICK_DIV - 1));
    assign w_sec_last = (r_sec == 6'd59);
    assign w_min_last = (r_min == 7'(MAX_MIN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre   <= '0;
            r_sec   <= '0;
            r_min   <= '0;
            r_sec_o <= '0;
            r_sec_t <= '0;
            r_min_o <= '0;
            r_min_t <= '0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (bus.clear) begin
            r_pre   <= '0;
            r_sec   <= '0;
            r_min   <= '0;
            r_sec_o <= '0;
            r_sec_t <= '0;
            r_min_o <= '0;
            r_min_t <= '0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_tick <= w_term;
            r_wrap <= w_term && w_sec_last && w_min_last;
            if (bus.run_enable)
                r_pre <= w_term ? '0 : r_pre + PW'(1);
            if (w_term) begin
                if (!w_sec_last) begin
                    r_sec <= r_sec + 6'd1;
                    if (r_sec_o == 4'd9) begin
                        r_sec_o <= '0;
                        r_sec_t <= r_sec_t + 4'd1;
                    end else begin
                        r_sec_o <= r_sec_o + 4'd1;
                    end
                end else begin
                    r_sec   <= '0;
                    r_sec_o <= '0;
                    r_sec_t <= '0;
                    // minute rollover: either wrap to 00 or step BCD digits
                    if (w_min_last) begin
                        r_min   <= '0;
                        r_min_o <= '0;
                        r_min_t <= '0;
                    end else begin
                        r_min <= r_min + 7'd1;
                        if (r_min_o == 4'd9) begin
                            r_min_o <= '0;
                            r_min_t <= r_min_t + 4'd1;
                        end else begin
                            r_min_o <= r_min_o + 4'd1;
                        end
                    end
                end
            end
        end
    end

    assign bus.seconds  = r_sec;
    assign bus.minutes  = r_min;
    assign bus.sec_bcd  = {r_sec_t, r_sec_o};
    assign bus.min_bcd  = {r_min_t, r_min_o};
    assign bus.sec_tick = r_tick;
    assign bus.wrap     = r_wrap;
endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Bench for stopwatch_time_counter: directed steps plus random
// enable/clear traffic against an elapsed-seconds reference model.
module tb_stopwatch_time_counter;
    localparam int TD = 4;
    localparam int MM = 2;
    localparam int PERIOD = 60 * (MM + 1);

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    int   m_cnt;
    int   m_total;
    bit   m_tick;
    bit   m_wrap;

    stopwatch_time_counter_if bus ();

    stopwatch_time_counter #(.TICK_DIV(TD), .MAX_MIN(MM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bcd(input int v);
        return 32'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic model_reset();
        m_cnt   = 0;
        m_total = 0;
        m_tick  = 0;
        m_wrap  = 0;
    endtask

    task automatic check_all(input string tag);
        int s, m;
        s = m_total % 60;
        m = m_total / 60;
        chk({tag, ".sec"},  32'(bus.seconds), 32'(s));
        chk({tag, ".min"},  32'(bus.minutes), 32'(m));
        chk({tag, ".sbcd"}, 32'(bus.sec_bcd), bcd(s));
        chk({tag, ".mbcd"}, 32'(bus.min_bcd), bcd(m));
        chk({tag, ".tick"}, 32'(bus.sec_tick), 32'(m_tick));
        chk({tag, ".wrap"}, 32'(bus.wrap), 32'(m_wrap));
    endtask

    // one clock with given inputs; model advances, outputs checked at +1
    task automatic step(input bit en, input bit clr, input string tag);
        bus.run_enable = en;
        bus.clear      = clr;
        @(posedge clk);
        m_tick = 0;
        m_wrap = 0;
        if (clr) begin
            m_cnt   = 0;
            m_total = 0;
        end else if (en) begin
            if (m_cnt == TD - 1) begin
                m_cnt  = 0;
                m_tick = 1;
                m_total++;
                if (m_total == PERIOD) begin
                    m_total = 0;
                    m_wrap  = 1;
                end
            end else begin
                m_cnt++;
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        model_reset();
        rst_n = 1'b0;
        bus.run_enable = 1'b0;
        bus.clear      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("in_reset");
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) step(0, 0, "idle");

        for (int i = 1; i <= 12; i++) begin
            step(1, 0, "basic");
            chk("basic_tick_at", 32'(bus.sec_tick), 32'(i % 4 == 0));
        end
        chk("basic_sec3", 32'(bus.seconds), 32'd3);
        chk("basic_bcd03", 32'(bus.sec_bcd), 32'h03);
        for (int i = 12; i < 240; i++) step(1, 0, "run");
        chk("min1_min", 32'(bus.minutes), 32'd1);
        chk("min1_sec", 32'(bus.seconds), 32'd0);
        chk("min1_bcd", 32'(bus.min_bcd), 32'h01);

        step(0, 1, "clr0");
        step(1, 0, "pr_a");
        step(1, 0, "pr_b");
        for (int i = 0; i < 10; i++) step(0, 0, "pause");
        step(1, 0, "resume1");
        chk("resume1_notick", 32'(bus.sec_tick), 32'd0);
        step(1, 0, "resume2");
        chk("resume2_tick", 32'(bus.sec_tick), 32'd1);
        chk("resume2_sec", 32'(bus.seconds), 32'd1);

        // drop enable on terminal edge; tick fires on first enabled edge
        step(1, 0, "te_a");
        step(1, 0, "te_b");
        step(1, 0, "te_c");
        step(0, 0, "te_drop");
        chk("te_drop_notick", 32'(bus.sec_tick), 32'd0);
        step(0, 0, "te_hold");
        step(1, 0, "te_resume");
        chk("te_resume_tick", 32'(bus.sec_tick), 32'd1);

        step(0, 1, "clr1");
        for (int i = 0; i < 179 * TD; i++) step(1, 0, "to259");
        chk("at259_min", 32'(bus.minutes), 32'd2);
        chk("at259_sec", 32'(bus.seconds), 32'd59);
        for (int i = 0; i < TD; i++) step(1, 0, "wrap");
        chk("wrap_pulse", 32'(bus.wrap), 32'd1);
        chk("wrap_tick", 32'(bus.sec_tick), 32'd1);
        chk("wrap_bcd", 32'({bus.min_bcd, bus.sec_bcd}), 32'h0000);
        step(1, 0, "post_wrap");
        chk("wrap_single", 32'(bus.wrap), 32'd0);

        step(0, 1, "clr2");
        for (int i = 0; i < 7 * TD + 3; i++) step(1, 0, "to07");
        chk("at07", 32'(bus.seconds), 32'd7);
        step(1, 1, "clr_term");
        chk("clr_term_tick", 32'(bus.sec_tick), 32'd0);
        chk("clr_term_sec", 32'(bus.seconds), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, "after_clr");
            chk("after_clr_tick", 32'(bus.sec_tick), 32'(i == 4));
        end

        step(0, 1, "clr3");
        for (int i = 0; i < 83 * TD; i++) step(1, 0, "to0123");
        chk("at0123", 32'({bus.min_bcd, bus.sec_bcd}), 32'h0123);
        step(1, 0, "pre_rst");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        #1 rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, "rst_restart");
            chk("rst_restart_tick", 32'(bus.sec_tick), 32'(i == 4));
        end

        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0,
                 "rand");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
